// File: rtl/load_que_recv_pkg.sv
// Shared load-queue types: queue/rob pointers, entry payload, and age-compare helpers.
// Pointers carry a flip bit above the index so that full and empty can be told apart.
package load_que_recv_pkg;

  localparam int LQ_SIZE  = 16;
  localparam int ALLOC_W  = 2;
  localparam int COMMIT_W = 2;
  localparam int SQ_SIZE  = 16;
  localparam int ROB_SIZE = 64;
  localparam int XLEN     = 64;
  localparam int PADDR_W  = 40;

  localparam int LQ_IDX_W     = $clog2(LQ_SIZE);
  localparam int SQ_IDX_W     = $clog2(SQ_SIZE);
  localparam int ROB_IDX_W    = $clog2(ROB_SIZE);
  localparam int ALLOC_NUM_W  = $clog2(ALLOC_W + 1);
  localparam int COMMIT_NUM_W = $clog2(COMMIT_W + 1);

  typedef logic [LQ_IDX_W:0]  lq_idx_t;  // {flip, idx}
  typedef logic [SQ_IDX_W:0]  sq_idx_t;
  typedef logic [PADDR_W-1:0] paddr_t;
  typedef logic [XLEN-1:0]    vaddr_t;
  typedef logic [XLEN/8-1:0]  bmask_t;

  typedef struct packed {
    logic                 flip;
    logic [ROB_IDX_W-1:0] idx;
  } rob_idx_t;

  typedef struct packed {
    vaddr_t          vaddr;
    paddr_t          paddr;
    bmask_t          loadmask;
    rob_idx_t        rob_idx;
    logic [XLEN-1:0] pc;
  } lq_entry_t;

  // True when a is older than b in program order.
  function automatic logic is_older(input rob_idx_t a, input rob_idx_t b);
    return (a.flip == b.flip) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

  // True when pos lies in the circular window [start, start+len).
  function automatic logic in_window(input logic [LQ_IDX_W-1:0] pos,
                                     input logic [LQ_IDX_W-1:0] start,
                                     input lq_idx_t             len);
    logic [LQ_IDX_W-1:0] off;
    off = pos - start;
    return {1'b0, off} < len;
  endfunction

endpackage

// File: rtl/load_que_recv_if.sv
// Loadpipe stage-2 to load-queue write bus.
interface load2que_if;
  import load_que_recv_pkg::*;

  logic            vld;
  lq_idx_t         lq_idx;
  sq_idx_t         sq_idx;
  vaddr_t          vaddr;
  paddr_t          paddr;
  bmask_t          loadmask;
  rob_idx_t        rob_idx;
  logic [XLEN-1:0] pc;

  modport master (output vld, lq_idx, sq_idx, vaddr, paddr, loadmask, rob_idx, pc);
  modport slave  (input  vld, lq_idx, sq_idx, vaddr, paddr, loadmask, rob_idx, pc);

endinterface

// File: rtl/load_que_recv_oldest_sel.sv
// Rotating-priority picker: first set request bit at or after i_head, wrapping around.
module lq_oldest_sel
  import load_que_recv_pkg::*;
#(
  parameter int N = LQ_SIZE
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_head,
  output logic                 o_vld,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int W = $clog2(N);

  logic [W-1:0] w_pos;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    o_vld = 1'b0;
    o_idx = i_head;
    w_pos = '0;
    // Scan youngest to oldest so the closest-to-head hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = i_head + W'(k);
      if (i_req[w_pos]) begin
        o_vld = 1'b1;
        o_idx = w_pos;
      end
    end
  end

endmodule

// File: rtl/load_que_recv.sv
// Load-queue storage: in-order alloc, s2 address write, commit from head, squash of the tail,
// and a registered store-vs-load RAW violation check reporting the oldest offender.
module load_que_recv
  import load_que_recv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  load2que_if.slave               if_s2,
  input  logic [ALLOC_NUM_W-1:0]  i_alloc_num,
  output logic                    o_alloc_rdy,
  output lq_idx_t                 o_alloc_lqIdx,
  input  logic [COMMIT_NUM_W-1:0] i_commit_num,
  input  logic                    i_squash_vld,
  input  lq_idx_t                 i_squash_lqIdx,
  input  logic                    i_st_vld,
  input  paddr_t                  i_st_paddr,
  input  bmask_t                  i_st_mask,
  input  rob_idx_t                i_st_robIdx,
  output logic                    o_viol_vld,
  output rob_idx_t                o_viol_robIdx,
  output logic [XLEN-1:0]         o_viol_pc
);

  lq_idx_t             r_head;
  lq_idx_t             r_tail;
  logic [LQ_SIZE-1:0]  r_vld;
  logic [LQ_SIZE-1:0]  r_addrvld;
  lq_entry_t           r_entry [LQ_SIZE];

  lq_idx_t             w_count;
  lq_idx_t             w_squash_len;
  logic                w_alloc_fire;
  logic [LQ_SIZE-1:0]  w_set;
  logic [LQ_SIZE-1:0]  w_clr;
  logic [LQ_IDX_W-1:0] w_s2_idx;
  logic [LQ_SIZE-1:0]  w_s2_onehot;
  logic                w_s2_fwd;
  logic                w_s2_wr;
  lq_entry_t           w_s2_entry;
  lq_entry_t           w_cand [LQ_SIZE];
  logic [LQ_SIZE-1:0]  w_req;
  logic                w_sel_vld;
  logic [LQ_IDX_W-1:0] w_sel_idx;
  logic                w_unused;

  assign w_count       = r_tail - r_head;
  assign o_alloc_rdy   = (lq_idx_t'(LQ_SIZE) - w_count) >= lq_idx_t'(ALLOC_W);
  assign o_alloc_lqIdx = r_tail;
  assign w_alloc_fire  = (i_alloc_num != '0) && o_alloc_rdy && !i_squash_vld;
  assign w_squash_len  = r_tail - i_squash_lqIdx;

  assign w_s2_idx    = if_s2.lq_idx[LQ_IDX_W-1:0];
  assign w_s2_onehot = LQ_SIZE'(1) << w_s2_idx;
  assign w_s2_fwd    = if_s2.vld && r_vld[w_s2_idx];
  // A write landing on an entry freed this same cycle must not resurrect its address.
  assign w_s2_wr     = w_s2_fwd && !w_clr[w_s2_idx];
  assign w_s2_entry  = '{vaddr:    if_s2.vaddr,
                         paddr:    if_s2.paddr,
                         loadmask: if_s2.loadmask,
                         rob_idx:  if_s2.rob_idx,
                         pc:       if_s2.pc};

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < LQ_SIZE; i++) begin
      w_set[i] = w_alloc_fire &&
                 in_window(LQ_IDX_W'(i), r_tail[LQ_IDX_W-1:0], lq_idx_t'(i_alloc_num));
      w_clr[i] = in_window(LQ_IDX_W'(i), r_head[LQ_IDX_W-1:0], lq_idx_t'(i_commit_num)) ||
                 (i_squash_vld &&
                  in_window(LQ_IDX_W'(i), i_squash_lqIdx[LQ_IDX_W-1:0], w_squash_len));
    end
  end

  // Same-cycle s2 data is forwarded into the check as if already stored.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < LQ_SIZE; i++) begin
      w_cand[i] = r_entry[i];
      if (w_s2_fwd && (w_s2_idx == LQ_IDX_W'(i))) w_cand[i] = w_s2_entry;
      w_req[i] = i_st_vld && !i_squash_vld &&
                 ((r_vld[i] && r_addrvld[i]) || (w_s2_fwd && (w_s2_idx == LQ_IDX_W'(i)))) &&
                 is_older(i_st_robIdx, w_cand[i].rob_idx) &&
                 (w_cand[i].paddr[PADDR_W-1:3] == i_st_paddr[PADDR_W-1:3]) &&
                 ((w_cand[i].loadmask & i_st_mask) != '0);
    end
  end

  lq_oldest_sel #(.N(LQ_SIZE)) u_oldest_sel (
    .i_req  (w_req),
    .i_head (r_head[LQ_IDX_W-1:0]),
    .o_vld  (w_sel_vld),
    .o_idx  (w_sel_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_vld         <= '0;
      r_addrvld     <= '0;
      o_viol_vld    <= 1'b0;
      o_viol_robIdx <= '0;
      o_viol_pc     <= '0;
    end else begin
      r_head     <= r_head + lq_idx_t'(i_commit_num);
      r_tail     <= i_squash_vld ? i_squash_lqIdx
                                 : r_tail + (w_alloc_fire ? lq_idx_t'(i_alloc_num) : '0);
      r_vld      <= (r_vld & ~w_clr) | w_set;
      r_addrvld  <= (r_addrvld & ~w_clr & ~w_set) | (w_s2_wr ? w_s2_onehot : '0);
      o_viol_vld <= w_sel_vld;
      if (w_sel_vld) begin
        o_viol_robIdx <= w_cand[w_sel_idx].rob_idx;
        o_viol_pc     <= w_cand[w_sel_idx].pc;
      end
    end
  end

  // NOTE: the payload array has no reset; vld/addrvld gate every use of its contents.
  always_ff @(posedge clk) begin
    if (w_s2_wr) r_entry[w_s2_idx] <= w_s2_entry;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!((i_alloc_num != '0) && !o_alloc_rdy));
      assert (!if_s2.vld || r_vld[w_s2_idx]);
      assert (lq_idx_t'(i_commit_num) <= w_count);
    end
  end

  always_comb begin
    w_unused = ^{if_s2.sq_idx, if_s2.lq_idx[LQ_IDX_W], i_st_paddr[2:0]};
    for (int i = 0; i < LQ_SIZE; i++) w_unused = w_unused ^ (^r_entry[i]);
  end

endmodule

// File: tb/tb_load_que_recv.sv
// Directed bench for load_que_recv: alloc/commit/wrap, RAW detection, age select, squash, reset.
module tb_load_que_recv;
  import load_que_recv_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [ALLOC_NUM_W-1:0]  i_alloc_num = '0;
  logic                    o_alloc_rdy;
  lq_idx_t                 o_alloc_lqIdx;
  logic [COMMIT_NUM_W-1:0] i_commit_num = '0;
  logic                    i_squash_vld = 1'b0;
  lq_idx_t                 i_squash_lqIdx = '0;
  logic                    i_st_vld = 1'b0;
  paddr_t                  i_st_paddr = '0;
  bmask_t                  i_st_mask = '0;
  rob_idx_t                i_st_robIdx = '0;
  logic                    o_viol_vld;
  rob_idx_t                o_viol_robIdx;
  logic [XLEN-1:0]         o_viol_pc;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load2que_if u_if ();

  load_que_recv u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_s2          (u_if),
    .i_alloc_num    (i_alloc_num),
    .o_alloc_rdy    (o_alloc_rdy),
    .o_alloc_lqIdx  (o_alloc_lqIdx),
    .i_commit_num   (i_commit_num),
    .i_squash_vld   (i_squash_vld),
    .i_squash_lqIdx (i_squash_lqIdx),
    .i_st_vld       (i_st_vld),
    .i_st_paddr     (i_st_paddr),
    .i_st_mask      (i_st_mask),
    .i_st_robIdx    (i_st_robIdx),
    .o_viol_vld     (o_viol_vld),
    .o_viol_robIdx  (o_viol_robIdx),
    .o_viol_pc      (o_viol_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rob_idx_t rob(input int idx);
    return '{flip: 1'b0, idx: ROB_IDX_W'(idx)};
  endfunction

  task automatic s2(input lq_idx_t idx, input int r, input paddr_t pa, input bmask_t m,
                    input logic [63:0] pc);
    u_if.vld      = 1'b1;
    u_if.lq_idx   = idx;
    u_if.rob_idx  = rob(r);
    u_if.paddr    = pa;
    u_if.vaddr    = 64'(pa);
    u_if.loadmask = m;
    u_if.pc       = pc;
  endtask

  task automatic st(input int r, input paddr_t pa, input bmask_t m);
    i_st_vld    = 1'b1;
    i_st_robIdx = rob(r);
    i_st_paddr  = pa;
    i_st_mask   = m;
  endtask

  task automatic idle();
    i_alloc_num  = '0;
    i_commit_num = '0;
    i_squash_vld = 1'b0;
    i_st_vld     = 1'b0;
    u_if.vld     = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    u_if.vld = 1'b0; u_if.lq_idx = '0; u_if.sq_idx = '0; u_if.rob_idx = '0;
    u_if.paddr = '0; u_if.vaddr = '0; u_if.loadmask = '0; u_if.pc = '0;

    // Reset state
    #12;
    check("rst_rdy", 64'(o_alloc_rdy), 64'd1);
    check("rst_tail", 64'(o_alloc_lqIdx), 64'd0);
    check("rst_viol_vld", 64'(o_viol_vld), 64'd0);
    check("rst_viol_rob", 64'(o_viol_robIdx), 64'd0);
    check("rst_viol_pc", o_viol_pc, 64'd0);
    rst_n = 1'b1;
    step();

    // Fill two per cycle until full
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fill_tail_%0d", k), 64'(o_alloc_lqIdx), 64'(2 * k));
      check($sformatf("fill_rdy_%0d", k), 64'(o_alloc_rdy), 64'd1);
      i_alloc_num = 2'd2;
      step();
    end
    idle();
    check("full_rdy", 64'(o_alloc_rdy), 64'd0);
    check("full_tail", 64'(o_alloc_lqIdx), 64'h10);
    check("full_count", 64'(u_dut.w_count), 64'd16);

    // Drain, then reallocate across the wrap
    i_commit_num = 2'd2;
    for (int k = 0; k < 8; k++) step();
    idle();
    check("empty_count", 64'(u_dut.w_count), 64'd0);
    check("empty_rdy", 64'(o_alloc_rdy), 64'd1);
    i_alloc_num = 2'd2;
    step();
    step();
    idle();
    check("wrap_tail", 64'(o_alloc_lqIdx), 64'h14);
    check("wrap_count", 64'(u_dut.w_count), 64'd4);

    // Basic RAW violation on entry {1,0}
    s2(5'h10, 5, 40'h1000, 8'h0F, 64'h8000_1000);
    step();
    u_if.vld = 1'b0;
    st(3, 40'h1002, 8'h0C);
    step();
    check("raw_vld", 64'(o_viol_vld), 64'd1);
    check("raw_rob", 64'(o_viol_robIdx), 64'd5);
    check("raw_pc", o_viol_pc, 64'h8000_1000);
    i_st_vld = 1'b0;
    step();
    check("raw_pulse", 64'(o_viol_vld), 64'd0);

    // Non-violating variants and same-word boundary
    st(3, 40'h1002, 8'hF0);
    step();
    check("nomask_vld", 64'(o_viol_vld), 64'd0);
    st(3, 40'h1008, 8'h0C);
    step();
    check("nextword_vld", 64'(o_viol_vld), 64'd0);
    st(7, 40'h1002, 8'h0C);
    step();
    check("younger_st_vld", 64'(o_viol_vld), 64'd0);
    st(5, 40'h1002, 8'h0C);
    step();
    check("same_rob_vld", 64'(o_viol_vld), 64'd0);
    st(3, 40'h1007, 8'h01);
    step();
    check("wordend_vld", 64'(o_viol_vld), 64'd1);
    idle();

    // Oldest select with head=12 and violators at idx 14 and 1
    pulse_reset();
    i_alloc_num = 2'd2;
    for (int k = 0; k < 6; k++) step();
    idle();
    i_commit_num = 2'd2;
    for (int k = 0; k < 6; k++) step();
    idle();
    i_alloc_num = 2'd2;
    for (int k = 0; k < 3; k++) step();
    idle();
    check("sel_tail", 64'(o_alloc_lqIdx), 64'h12);
    s2(5'h0E, 10, 40'h2000, 8'h01, 64'hA000);
    step();
    s2(5'h11, 8, 40'h2000, 8'h03, 64'hB000);
    step();
    u_if.vld = 1'b0;
    st(2, 40'h2000, 8'h01);
    step();
    check("sel_vld", 64'(o_viol_vld), 64'd1);
    check("sel_rob", 64'(o_viol_robIdx), 64'd10);
    check("sel_pc", o_viol_pc, 64'hA000);
    st(2, 40'h2000, 8'h02);
    step();
    check("sel_only1_rob", 64'(o_viol_robIdx), 64'd8);
    check("sel_only1_pc", o_viol_pc, 64'hB000);
    s2(5'h0D, 9, 40'h3000, 8'hFF, 64'hC000);
    st(2, 40'h3004, 8'h10);
    step();
    check("fwd_vld", 64'(o_viol_vld), 64'd1);
    check("fwd_rob", 64'(o_viol_robIdx), 64'd9);
    check("fwd_pc", o_viol_pc, 64'hC000);
    idle();

    // Squash to 6 with alloc and s2 write to 7 in the same cycle
    pulse_reset();
    i_alloc_num = 2'd2;
    for (int k = 0; k < 5; k++) step();
    idle();
    s2(5'd5, 20, 40'h4000, 8'hFF, 64'hD000);
    step();
    s2(5'd8, 22, 40'h4000, 8'hFF, 64'hE000);
    step();
    u_if.vld = 1'b0;
    st(21, 40'h4000, 8'h01);
    step();
    check("presq_vld", 64'(o_viol_vld), 64'd1);
    check("presq_rob", 64'(o_viol_robIdx), 64'd22);
    i_squash_vld   = 1'b1;
    i_squash_lqIdx = 5'd6;
    i_alloc_num    = 2'd2;
    s2(5'd7, 21, 40'h4000, 8'hFF, 64'hF000);
    step();
    idle();
    check("sq_viol_clr", 64'(o_viol_vld), 64'd0);
    check("sq_tail", 64'(o_alloc_lqIdx), 64'd6);
    check("sq_vld_vec", 64'(u_dut.r_vld), 64'h003F);
    check("sq_addrvld_vec", 64'(u_dut.r_addrvld), 64'h0020);
    st(21, 40'h4000, 8'h01);
    step();
    check("postsq_none", 64'(o_viol_vld), 64'd0);
    st(1, 40'h4000, 8'h01);
    step();
    check("postsq_vld", 64'(o_viol_vld), 64'd1);
    check("postsq_rob", 64'(o_viol_robIdx), 64'd20);
    check("postsq_pc", o_viol_pc, 64'hD000);

    // Asynchronous reset mid-operation
    #2;
    idle();
    rst_n = 1'b0;
    #1;
    check("arst_viol_vld", 64'(o_viol_vld), 64'd0);
    check("arst_viol_rob", 64'(o_viol_robIdx), 64'd0);
    check("arst_viol_pc", o_viol_pc, 64'd0);
    check("arst_tail", 64'(o_alloc_lqIdx), 64'd0);
    check("arst_rdy", 64'(o_alloc_rdy), 64'd1);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
